// File: rtl/idu_stage.sv
// idu_stage: instruction decode stage between the fetch unit (IFU) and the
// execute unit (EXU).
//
// Purpose:
//   Accepts {pc, inst} from the IFU over a valid/ready handshake. It decodes
//   the register indices, the sign-extended immediate, the instruction class
//   and the writeback enable. The decoded entry is registered and presented
//   to the EXU over a second valid/ready handshake. A main register M drives
//   out_*. A skid register S holds one extra entry, so in_ready depends only
//   on a flop and never on out_ready. flush discards both held entries and
//   any input offered in the same cycle.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  IFU handshake (in_ready = !skid_valid)
//   in_pc, in_inst     incoming pc and raw instruction word
//   flush              drop every held entry and the same-cycle input
//   out_valid/ready    EXU handshake
//   out_pc, out_inst   pc and raw instruction of the output entry
//   out_rs1/rs2/rd     register indices (low RF_ADDR_W bits of each field)
//   out_imm            sign-extended immediate
//   out_class          instruction class code (15 = unknown opcode)
//   out_rd_wen         register writeback required
//   out_illegal        only present when IDU_ILLEGAL_CHECK_EN is defined
//
// Build option:
//   IDU_ILLEGAL_CHECK_EN - adds out_illegal. It flags unknown opcodes, a
//   non-32-bit encoding (inst[1:0] != 2'b11), and register indices >= 16
//   when RF_ADDR_W == 4. An illegal entry never writes back.

module idu_stage #(
  parameter int ADDR_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_pc,
  input  logic [31:0]          in_inst,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_pc,
  output logic [31:0]          out_inst,
  output logic [RF_ADDR_W-1:0] out_rs1,
  output logic [RF_ADDR_W-1:0] out_rs2,
  output logic [RF_ADDR_W-1:0] out_rd,
  output logic [31:0]          out_imm,
  output logic [3:0]           out_class,
`ifdef IDU_ILLEGAL_CHECK_EN
  output logic                 out_illegal,
`endif
  output logic                 out_rd_wen
);

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] CL_ALU_R  = 4'd0;
  localparam logic [3:0] CL_ALU_I  = 4'd1;
  localparam logic [3:0] CL_LOAD   = 4'd2;
  localparam logic [3:0] CL_STORE  = 4'd3;
  localparam logic [3:0] CL_BRANCH = 4'd4;
  localparam logic [3:0] CL_JAL    = 4'd5;
  localparam logic [3:0] CL_JALR   = 4'd6;
  localparam logic [3:0] CL_LUI    = 4'd7;
  localparam logic [3:0] CL_AUIPC  = 4'd8;
  localparam logic [3:0] CL_SYSTEM = 4'd9;
  localparam logic [3:0] CL_UNK    = 4'd15;

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [31:0]          inst;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
    logic [31:0]          imm;
    logic [3:0]           cls;
`ifdef IDU_ILLEGAL_CHECK_EN
    logic                 illegal;
`endif
    logic                 rd_wen;
  } entry_t;

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        wb_class;
  entry_t      dec;

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec      = '0;
    wb_class = 1'b0;
    dec.pc   = in_pc;
    dec.inst = in_inst;
    dec.rs1  = in_inst[15 +: RF_ADDR_W];
    dec.rs2  = in_inst[20 +: RF_ADDR_W];
    dec.rd   = in_inst[7  +: RF_ADDR_W];

    case (in_inst[6:0])
      OP_ALU_R:  begin dec.cls = CL_ALU_R;                      wb_class = 1'b1; end
      OP_ALU_I:  begin dec.cls = CL_ALU_I;   dec.imm = imm_i;   wb_class = 1'b1; end
      OP_LOAD:   begin dec.cls = CL_LOAD;    dec.imm = imm_i;   wb_class = 1'b1; end
      OP_STORE:  begin dec.cls = CL_STORE;   dec.imm = imm_s;                    end
      OP_BRANCH: begin dec.cls = CL_BRANCH;  dec.imm = imm_b;                    end
      OP_JAL:    begin dec.cls = CL_JAL;     dec.imm = imm_j;   wb_class = 1'b1; end
      OP_JALR:   begin dec.cls = CL_JALR;    dec.imm = imm_i;   wb_class = 1'b1; end
      OP_LUI:    begin dec.cls = CL_LUI;     dec.imm = imm_u;   wb_class = 1'b1; end
      OP_AUIPC:  begin dec.cls = CL_AUIPC;   dec.imm = imm_u;   wb_class = 1'b1; end
      OP_SYSTEM: begin dec.cls = CL_SYSTEM;  dec.imm = imm_i;   wb_class = 1'b1; end
      default:   begin dec.cls = CL_UNK;                                         end
    endcase

    // x0 is hardwired, so a write to it is never requested.
    dec.rd_wen = wb_class && (dec.rd != '0);

`ifdef IDU_ILLEGAL_CHECK_EN
    dec.illegal = (dec.cls == CL_UNK) || (in_inst[1:0] != 2'b11) ||
                  ((RF_ADDR_W == 4) && (in_inst[19] || in_inst[24] || in_inst[11]));
    if (dec.illegal) dec.rd_wen = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // Main (M) + skid (S) registers
  // ---------------------------------------------------------------------
  entry_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   in_xfer, out_xfer;

  assign in_ready = !s_valid_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = m_valid_q && out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;

    if (flush) begin
      // Data is left as is; only the valids matter once the entries are dropped.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (out_xfer) begin
      if (s_valid_q) begin
        // in_ready is low while S is full, so no input can collide here.
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else if (in_xfer) begin
        m_d       = dec;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      // M is stalled: park the new entry behind it so order is kept.
      if (in_xfer) begin
        s_d       = dec;
        s_valid_d = 1'b1;
      end
    end else if (in_xfer) begin
      m_d       = dec;
      m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid  = m_valid_q;
  assign out_pc     = m_q.pc;
  assign out_inst   = m_q.inst;
  assign out_rs1    = m_q.rs1;
  assign out_rs2    = m_q.rs2;
  assign out_rd     = m_q.rd;
  assign out_imm    = m_q.imm;
  assign out_class  = m_q.cls;
  assign out_rd_wen = m_q.rd_wen;
`ifdef IDU_ILLEGAL_CHECK_EN
  assign out_illegal = m_q.illegal;
`endif

endmodule

// File: tb/tb_idu_stage.sv
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_class;
  logic        out_rd_wen;
`ifdef IDU_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idu_stage #(.ADDR_W(32), .RF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_class(out_class),
`ifdef IDU_ILLEGAL_CHECK_EN
    .out_illegal(out_illegal),
`endif
    .out_rd_wen(out_rd_wen)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_pc",    out_pc, 0);
    chk("rst_out_imm",   out_imm, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_inst",  out_inst, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // addi x1,x0,5
    drive(1'b1, 32'h8000_0000, 32'h0050_0093);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_class", out_class, 1);
    chk("addi_rd",    out_rd, 1);
    chk("addi_rs1",   out_rs1, 0);
    chk("addi_rs2",   out_rs2, 5);
    chk("addi_imm",   out_imm, 32'h0000_0005);
    chk("addi_wen",   out_rd_wen, 1);
    chk("addi_pc",    out_pc, 32'h8000_0000);
    chk("addi_inst",  out_inst, 32'h0050_0093);

    // jal x1,8
    drive(1'b1, 32'h8000_0004, 32'h0080_00EF);
    tick();
    chk("jal_class", out_class, 5);
    chk("jal_imm",   out_imm, 32'h0000_0008);
    chk("jal_wen",   out_rd_wen, 1);
    chk("jal_pc",    out_pc, 32'h8000_0004);

    // beq x0,x0,-4
    drive(1'b1, 32'h8000_0008, 32'hFE00_0EE3);
    tick();
    chk("beq_class", out_class, 4);
    chk("beq_imm",   out_imm, 32'hFFFF_FFFC);
    chk("beq_wen",   out_rd_wen, 0);

    // sw x2,8(x1)
    drive(1'b1, 32'h8000_000C, 32'h0020_A423);
    tick();
    chk("sw_class", out_class, 3);
    chk("sw_imm",   out_imm, 32'h0000_0008);
    chk("sw_rs1",   out_rs1, 1);
    chk("sw_rs2",   out_rs2, 2);
    chk("sw_wen",   out_rd_wen, 0);

    // lui x1,0x12345
    drive(1'b1, 32'h8000_0010, 32'h1234_50B7);
    tick();
    chk("lui_class", out_class, 7);
    chk("lui_imm",   out_imm, 32'h1234_5000);
    chk("lui_wen",   out_rd_wen, 1);

    // add x0,x1,x2: writeback class but rd = x0
    drive(1'b1, 32'h8000_0014, 32'h0020_8033);
    tick();
    chk("add_x0_class", out_class, 0);
    chk("add_x0_imm",   out_imm, 0);
    chk("add_x0_wen",   out_rd_wen, 0);

    // unknown opcode
    drive(1'b1, 32'h8000_0018, 32'h0000_000B);
    tick();
    chk("unk_class", out_class, 15);
    chk("unk_wen",   out_rd_wen, 0);
    chk("unk_imm",   out_imm, 0);
`ifdef IDU_ILLEGAL_CHECK_EN
    chk("unk_illegal", out_illegal, 1);
`endif
    // unknown opcode with rd = x1 still has no writeback
    drive(1'b1, 32'h8000_001C, 32'h0000_008B);
    tick();
    chk("unk_rd1_class", out_class, 15);
    chk("unk_rd1_wen",   out_rd_wen, 0);

    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("idle_valid", out_valid, 0);

    // Backpressure: three back-to-back entries, the third is held off
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h0050_0093);
    tick();
    chk("bp0_valid", out_valid, 1);
    chk("bp0_ready", in_ready, 1);
    drive(1'b1, 32'h8000_0004, 32'h0060_0113);
    tick();
    chk("bp1_pc",    out_pc, 32'h8000_0000);
    chk("bp1_ready", in_ready, 0);
    drive(1'b1, 32'h8000_0008, 32'h0070_0193);
    tick();
    chk("bp2_pc",    out_pc, 32'h8000_0000);
    chk("bp2_imm",   out_imm, 5);
    chk("bp2_ready", in_ready, 0);
    tick();
    chk("bp3_pc",    out_pc, 32'h8000_0000);
    chk("bp3_rd",    out_rd, 1);
    out_ready = 1'b1;
    tick();
    chk("drain1_pc",    out_pc, 32'h8000_0004);
    chk("drain1_imm",   out_imm, 6);
    chk("drain1_rd",    out_rd, 2);
    chk("drain1_ready", in_ready, 1);
    tick();
    chk("drain2_valid", out_valid, 1);
    chk("drain2_pc",    out_pc, 32'h8000_0008);
    chk("drain2_imm",   out_imm, 7);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain3_valid", out_valid, 0);

    // Flush with M and S both full and an input offered
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0010, 32'h0050_0093);
    tick();
    drive(1'b1, 32'h8000_0014, 32'h0060_0113);
    tick();
    chk("fl_full_ready", in_ready, 0);
    chk("fl_full_valid", out_valid, 1);
    drive(1'b1, 32'h8000_0018, 32'h0070_0193);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("fl_after_valid", out_valid, 0);

    // Flush while an input would otherwise be accepted (M full, S empty)
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0020, 32'h0050_0093);
    tick();
    chk("fl2_pre_ready", in_ready, 1);
    drive(1'b1, 32'h8000_0024, 32'h0060_0113);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl2_valid", out_valid, 0);
    out_ready = 1'b1;
    tick();
    chk("fl2_after_valid", out_valid, 0);

    // Asynchronous reset mid-stall with both entries held
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0030, 32'h0050_0093);
    tick();
    drive(1'b1, 32'h8000_0034, 32'h0060_0113);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_ready", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid_now", out_valid, 0);
    chk("ar_pc_now",    out_pc, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_release_ready", in_ready, 1);
    chk("ar_release_valid", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0040, 32'h0050_0093);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_resume_valid", out_valid, 1);
    chk("ar_resume_pc",    out_pc, 32'h8000_0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
